count_hex_uart_framer: RTL and testbench
========================================

// Module: count_hex_uart_framer
// PURPOSE
//   Sits between the counter and uart_transmitter. Takes a snapshot of the count word.
//   Sends it as ASCII hex text, MSB nibble first, optionally followed by CR LF.
//   Issues one byte at a time to the transmitter using a start/busy handshake.
//   One frame is in flight at a time. Requests that arrive while busy are dropped and flagged.
// PARAMETERS
//   DATA_W       32  count word width; must be a multiple of 4 (DATA_W/4 hex chars)
//   SEND_CRLF    1   1: append 0x0D,0x0A after the hex chars; 0: hex chars only
//   ACK_TIMEOUT  16  max cycles from o_uart_start until i_uart_busy must rise
// PORTS
//   clk           in   1       system clock (the generated clock, same as the counter and UART)
//   i_reset_n     in   1       asynchronous, active-low reset
//   i_valid       in   1       request to send i_data
//   i_data        in   DATA_W  count value to print
//   o_ready       out  1       high in IDLE; a request is accepted only when i_valid & o_ready
//   o_uart_start  out  1       one-cycle start pulse to the transmitter (i_start_transmission)
//   o_uart_data   out  8       byte for the transmitter
//   i_uart_busy   in   1       transmitter busy; rises after start, falls when the stop bit is done
//   o_overrun     out  1       sticky: i_valid was seen while o_ready=0
//   o_error       out  1       sticky: ack timeout occurred
// BEHAVIOUR
//   Clock and reset
//   - Single clock domain. i_reset_n low asynchronously clears all state.
//   - Reset values: state=IDLE, o_ready=1, o_uart_start=0, o_uart_data=8'h00, o_overrun=0, o_error=0.
//   - Asserting reset mid-frame aborts the frame immediately. No further bytes are issued.
//   Frame setup
//   - N = DATA_W/4 + 2*SEND_CRLF chars per frame; char index counter is $clog2(N+1) bits.
//   - Accept on i_valid&o_ready: latch i_data into a shadow register, set idx=0, go to LOAD.
//   - Later changes on i_data do not affect a frame in progress.
//   Character encoding
//   - Char idx < DATA_W/4 takes nibble DATA_W-1-4*idx downto DATA_W-4-4*idx.
//   - Nibble 0-9 encodes to 8'h30+n. Nibble A-F encodes to 8'h41+(n-10), uppercase.
//   - Char idx = DATA_W/4 is 8'h0D; idx = DATA_W/4+1 is 8'h0A (only when SEND_CRLF=1).
//   State machine: IDLE -> LOAD -> WAIT_ACK -> WAIT_DONE -> (LOAD | IDLE)
//   - LOAD (1 cycle): drive o_uart_data=char(idx) and o_uart_start=1, reset the timeout counter,
//     go to WAIT_ACK.
//   - WAIT_ACK: o_uart_start=0 and o_uart_data held.
//     If i_uart_busy=1, go to WAIT_DONE.
//     Otherwise, if the timer reaches ACK_TIMEOUT-1, set o_error and go to IDLE (frame abandoned).
//   - WAIT_DONE: hold o_uart_data until i_uart_busy=0, then idx++.
//     If idx==N-1 before the increment, go to IDLE; otherwise go to LOAD.
//   - Byte pacing: at least 1 idle cycle between busy falling and the next start pulse (the LOAD cycle).
//   Boundary conditions
//   - i_uart_busy already high when entering WAIT_ACK counts as the ack (no false timeout).
//   - i_valid during a frame: ignored and o_overrun set. This holds even in the cycle the frame finishes.
//   - i_valid while in IDLE is accepted: o_ready=1 there, so a back-to-back request the cycle after
//     returning to IDLE is accepted.
//   - o_overrun and o_error clear only on reset.
//   - Value wrap: an all-ones count prints "FFFFFFFF"; zero prints "00000000" (no leading-zero blanking).
// TESTING
//   - Reset check: i_reset_n=0 -> o_ready=1, o_uart_start=0, o_uart_data=00, flags 0.
//     Release reset -> IDLE held with no start pulses.
//   - Full frame: i_data=32'h00C0FFEE, model UART busy for 10 cycles per byte.
//     Bytes must be 30 30 43 30 46 46 45 45 0D 0A, exactly 10 start pulses,
//     and o_ready returns high after the last busy falls.
//   - Extremes: 32'hFFFFFFFF -> "FFFFFFFF\r\n"; 32'h00000000 -> "00000000\r\n".
//     With SEND_CRLF=0, exactly 8 bytes are sent.
//   - Overrun: pulse i_valid with 32'h12345678 mid-frame.
//     The frame continues with the original data, o_overrun=1, and the second value is never sent.
//   - Timeout: UART model never raises busy.
//     o_error=1 exactly ACK_TIMEOUT cycles after the start pulse, FSM returns to IDLE,
//     and the next request is sent normally.
//   - Reset mid-frame: assert i_reset_n=0 during byte 4.
//     Outputs clear asynchronously, and after release no further bytes are issued until a new i_valid.

Source files
------------

// File: rtl/count_hex_uart_framer.sv
// count_hex_uart_framer: snapshots a count word and prints it as uppercase ASCII hex,
// MSB nibble first with optional CR LF, one byte at a time over a start/busy UART handshake.
module count_hex_uart_framer #(
  parameter int DATA_W      = 32,
  parameter int SEND_CRLF   = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_uart_start,
  output logic [7:0]        o_uart_data,
  input  logic              i_uart_busy,
  output logic              o_overrun,
  output logic              o_error
);
  localparam int NHEX  = DATA_W / 4;
  localparam int NCHAR = NHEX + 2 * SEND_CRLF;
  localparam int IDX_W = $clog2(NCHAR + 1);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_CR   = IDX_W'(NHEX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHAR - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shadow;
  logic [IDX_W-1:0]  r_idx;
  logic [TMR_W-1:0]  r_timer;
  logic              r_ready;
  logic              r_start;
  logic [7:0]        r_data;
  logic              r_overrun;
  logic              r_error;

  logic [DATA_W-1:0] w_shifted;
  logic [3:0]        w_nibble;
  logic [7:0]        w_char;

  // Shifting the snapshot left by 4*idx brings the current nibble to the top.
  always_comb begin
    w_shifted = r_shadow << {r_idx, 2'b00};
    w_nibble  = w_shifted[DATA_W-1 -: 4];
    if (r_idx == IDX_CR)
      w_char = 8'h0D;
    else if (r_idx > IDX_CR)
      w_char = 8'h0A;
    else if (w_nibble < 4'd10)
      w_char = 8'h30 + {4'h0, w_nibble};
    else
      w_char = 8'h37 + {4'h0, w_nibble};
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_shadow  <= '0;
      r_idx     <= '0;
      r_timer   <= '0;
      r_ready   <= 1'b1;
      r_start   <= 1'b0;
      r_data    <= 8'h00;
      r_overrun <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (i_valid && !r_ready)
        r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_shadow <= i_data;
            r_idx    <= '0;
            r_ready  <= 1'b0;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_data  <= w_char;
          r_start <= 1'b1;
          r_timer <= '0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_uart_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_timer == TMR_LAST) begin
            r_error <= 1'b1;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!i_uart_busy) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == IDX_LAST) begin
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready      = r_ready;
  assign o_uart_start = r_start;
  assign o_uart_data  = r_data;
  assign o_overrun    = r_overrun;
  assign o_error      = r_error;

endmodule

// File: tb/tb_count_hex_uart_framer.sv
// Bench for count_hex_uart_framer: two instances (with and without CR LF) each driven by a
// small UART busy model; received bytes are compared against a text model of the frame.
module tb_count_hex_uart_framer;
  localparam int DW       = 32;
  localparam int TMO      = 16;
  localparam int BUSY_LEN = 10;
  localparam int LIMIT    = 3000;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  logic          valid0 = 1'b0, valid1 = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          ready0, start0, ovr0, err0, busy0;
  logic          ready1, start1, ovr1, err1, busy1;
  logic [7:0]    udata0, udata1, cur0, cur1;
  int            cnt0, cnt1;
  int            starts0 = 0, starts1 = 0, holdErr = 0;
  bit            noAck0 = 1'b0;
  logic [7:0]    got0[$], got1[$];

  int checks = 0;
  int errors = 0;

  count_hex_uart_framer #(.DATA_W(DW), .SEND_CRLF(1), .ACK_TIMEOUT(TMO)) dut0 (
    .clk(clk), .i_reset_n(rstN), .i_valid(valid0), .i_data(data0), .o_ready(ready0),
    .o_uart_start(start0), .o_uart_data(udata0), .i_uart_busy(busy0),
    .o_overrun(ovr0), .o_error(err0));

  count_hex_uart_framer #(.DATA_W(DW), .SEND_CRLF(0), .ACK_TIMEOUT(TMO)) dut1 (
    .clk(clk), .i_reset_n(rstN), .i_valid(valid1), .i_data(data1), .o_ready(ready1),
    .o_uart_start(start1), .o_uart_data(udata1), .i_uart_busy(busy1),
    .o_overrun(ovr1), .o_error(err1));

  // UART models: capture the byte on the start pulse, stay busy BUSY_LEN cycles, and
  // flag any change of the data byte while busy.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy0 <= 1'b0;
      cnt0  <= 0;
    end else begin
      if (start0) starts0 <= starts0 + 1;
      if (start0 && !noAck0) begin
        got0.push_back(udata0);
        cur0  <= udata0;
        busy0 <= 1'b1;
        cnt0  <= BUSY_LEN;
      end else if (cnt0 > 0) begin
        if (udata0 !== cur0) holdErr <= holdErr + 1;
        cnt0 <= cnt0 - 1;
        if (cnt0 == 1) busy0 <= 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy1 <= 1'b0;
      cnt1  <= 0;
    end else begin
      if (start1) starts1 <= starts1 + 1;
      if (start1) begin
        got1.push_back(udata1);
        cur1  <= udata1;
        busy1 <= 1'b1;
        cnt1  <= BUSY_LEN;
      end else if (cnt1 > 0) begin
        cnt1 <= cnt1 - 1;
        if (cnt1 == 1) busy1 <= 1'b0;
      end
    end
  end

  function automatic bq_t expFrame(input logic [DW-1:0] d, input bit crlf);
    bq_t q;
    for (int i = 0; i < DW / 4; i++) begin
      int n;
      n = int'((d >> (DW - 4 - 4 * i)) & 32'hF);
      q.push_back((n < 10) ? 8'(48 + n) : 8'(65 + (n - 10)));
    end
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  function automatic bq_t sliceFrom(input int sel, input int base);
    bq_t q;
    if (sel == 0) begin
      for (int i = base; i < got0.size(); i++) q.push_back(got0[i]);
    end else begin
      for (int i = base; i < got1.size(); i++) q.push_back(got1[i]);
    end
    return q;
  endfunction

  function automatic bit sameQ(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++)
      if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string hexQ(input bq_t q);
    string s = "";
    for (int i = 0; i < q.size(); i++) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic launch(input int sel, input logic [DW-1:0] d);
    int n = 0;
    while (!(sel == 0 ? ready0 : ready1) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("[TB] FAIL launch%0d: ready=0 required=1 within %0d cycles", sel, LIMIT);
    end
    if (sel == 0) begin valid0 = 1'b1; data0 = d; end
    else          begin valid1 = 1'b1; data1 = d; end
    @(negedge clk);
    if (sel == 0) begin valid0 = 1'b0; data0 = $urandom; end
    else          begin valid1 = 1'b0; data1 = $urandom; end
  endtask

  task automatic waitIdle(input int sel);
    int n = 0;
    while (!((sel == 0) ? (ready0 && !busy0) : (ready1 && !busy1)) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("[TB] FAIL idle%0d: frame still running after %0d cycles", sel, LIMIT);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #12;
    checks++;
    if ({ready0, start0, udata0, ovr0, err0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset0: got rdy/st/data/ovr/err=%b/%b/%h/%b/%b required 1/0/00/0/0",
               ready0, start0, udata0, ovr0, err0);
    end
    checks++;
    if ({ready1, start1, udata1, ovr1, err1} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset1: got rdy/st/data/ovr/err=%b/%b/%h/%b/%b required 1/0/00/0/0",
               ready1, start1, udata1, ovr1, err1);
    end
    @(negedge clk);
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (starts0 + starts1 != 0 || ready0 !== 1'b1 || ready1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: starts=%0d ready=%b%b required starts=0 ready=11",
               starts0 + starts1, ready0, ready1);
    end
  endtask

  task automatic test_frame(input int sel, input logic [DW-1:0] d);
    int  base, s0, sNow;
    bq_t got, exp;
    base = (sel == 0) ? got0.size() : got1.size();
    s0   = (sel == 0) ? starts0 : starts1;
    launch(sel, d);
    waitIdle(sel);
    got  = sliceFrom(sel, base);
    exp  = expFrame(d, sel == 0);
    sNow = (sel == 0) ? starts0 : starts1;
    checks++;
    if (!sameQ(got, exp)) begin
      errors++;
      $display("[TB] FAIL frame%0d %h: got %s required %s", sel, d, hexQ(got), hexQ(exp));
    end
    checks++;
    if (sNow - s0 != exp.size()) begin
      errors++;
      $display("[TB] FAIL starts%0d %h: got %0d pulses required %0d", sel, d, sNow - s0, exp.size());
    end
    checks++;
    if ((sel == 0 ? ready0 : ready1) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after%0d: got 0 required 1", sel);
    end
  endtask

  task automatic test_full_frame();
    test_frame(0, 32'h00C0FFEE);
    test_frame(0, 32'hFFFFFFFF);
    test_frame(0, 32'h00000000);
    repeat (4) test_frame(0, $urandom);
  endtask

  task automatic test_no_crlf();
    test_frame(1, 32'hFFFFFFFF);
    test_frame(1, 32'h00000000);
    repeat (2) test_frame(1, $urandom);
  endtask

  task automatic test_overrun();
    int  base;
    logic [DW-1:0] d;
    bq_t got, exp;
    d    = $urandom;
    base = got0.size();
    launch(0, d);
    repeat (30) @(negedge clk);
    valid0 = 1'b1;
    data0  = 32'h12345678;
    @(negedge clk);
    valid0 = 1'b0;
    waitIdle(0);
    repeat (50) @(negedge clk);
    got = sliceFrom(0, base);
    exp = expFrame(d, 1'b1);
    checks++;
    if (!sameQ(got, exp)) begin
      errors++;
      $display("[TB] FAIL overrun_frame: got %s required %s", hexQ(got), hexQ(exp));
    end
    checks++;
    if (ovr0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_flag: got %b required 1", ovr0);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int t = 0;
    int s0;
    noAck0 = 1'b1;
    s0 = starts0;
    launch(0, $urandom);
    while (!start0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (!err0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != TMO) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got %0d cycles required %0d", t, TMO);
    end
    checks++;
    if (ready0 !== 1'b1 || starts0 - s0 != 1) begin
      errors++;
      $display("[TB] FAIL timeout_idle: got ready=%b starts=%0d required ready=1 starts=1",
               ready0, starts0 - s0);
    end
    noAck0 = 1'b0;
    test_frame(0, $urandom);
    checks++;
    if (err0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL error_sticky: got %b required 1", err0);
    end
  endtask

  task automatic test_back_to_back();
    int  base;
    int  n = 0;
    logic [DW-1:0] a, b;
    bq_t got, exp, expB;
    pulseReset();
    checks++;
    if ({ovr0, err0} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL flags_cleared: got ovr/err=%b%b required 00", ovr0, err0);
    end
    a = $urandom;
    b = $urandom;
    base = got0.size();
    launch(0, a);
    while (!(got0.size() == base + 10 && !busy0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    valid0 = 1'b1;
    data0  = b;
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b1 || ovr0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL finish_cycle: got ready=%b ovr=%b required 1/1", ready0, ovr0);
    end
    @(negedge clk);
    valid0 = 1'b0;
    checks++;
    if (ready0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got ready=%b required 0", ready0);
    end
    waitIdle(0);
    got  = sliceFrom(0, base);
    exp  = expFrame(a, 1'b1);
    expB = expFrame(b, 1'b1);
    foreach (expB[i]) exp.push_back(expB[i]);
    checks++;
    if (!sameQ(got, exp)) begin
      errors++;
      $display("[TB] FAIL b2b_bytes: got %s required %s", hexQ(got), hexQ(exp));
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, s0;
    int n = 0;
    base = got0.size();
    s0   = starts0;
    launch(0, $urandom);
    while (got0.size() < base + 4 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({ready0, start0, udata0, ovr0, err0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got rdy/st/data/ovr/err=%b/%b/%h/%b/%b required 1/0/00/0/0",
               ready0, start0, udata0, ovr0, err0);
    end
    @(negedge clk);
    rstN = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (got0.size() - base != 4 || starts0 - s0 != 4) begin
      errors++;
      $display("[TB] FAIL abort: got %0d bytes %0d starts required 4/4",
               got0.size() - base, starts0 - s0);
    end
    test_frame(0, $urandom);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_no_crlf();
    test_overrun();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (holdErr != 0) begin
      errors++;
      $display("[TB] FAIL data_hold: got %0d changes while busy required 0", holdErr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
